// File: rtl/gen1_pkg.sv
// Gen1 link-layer constants shared by the SKP inserter and its timer.
// Symbol encodings, the SKP ordered-set word and the inserter state type.
package gen1_pkg;

  localparam logic [7:0]  K28_5       = 8'hBC;
  localparam logic [7:0]  K28_0       = 8'h1C;
  localparam logic [31:0] SKP_WORD    = {K28_0, K28_0, K28_0, K28_5};
  localparam logic [1:0]  DATA_LEN_4B = 2'b10;

  typedef enum logic {
    ST_PASS,
    ST_SKP_WAIT
  } skp_state_e;

endpackage

// File: rtl/gen1_skp_timer.sv
// SKP interval counter and forced-SKP request latch.
// Raises skp_pending_o until a SKP word is actually emitted.
module gen1_skp_timer #(
  parameter int SKP_INTERVAL_WORDS = 295
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic skp_req_i,
  input  logic word_sent_i,
  input  logic skp_sent_i,
  output logic skp_pending_o
);

  localparam int CW = $clog2(SKP_INTERVAL_WORDS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(SKP_INTERVAL_WORDS);

  logic [CW-1:0] cnt_q;
  logic          req_q;

  // Emission clears the latch even if a new request arrives that cycle,
  // so a request coinciding with a SKP never produces a second one.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      req_q <= 1'b0;
    end else begin
      if (skp_sent_i) begin
        cnt_q <= '0;
      end else if (word_sent_i && cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (skp_sent_i) begin
        req_q <= 1'b0;
      end else if (skp_req_i) begin
        req_q <= 1'b1;
      end
    end
  end

  assign skp_pending_o = (cnt_q == CNT_MAX) || req_q;

endmodule

// File: rtl/gen1_skp_inserter.sv
// Gen1 SKP ordered-set inserter in front of the scrambler.
// Emits PASS, SKP or IDLE every cycle; never splits a TS ordered set.
module gen1_skp_inserter
  import gen1_pkg::*;
#(
  parameter int SKP_INTERVAL_WORDS = 295
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_data_i,
  input  logic [3:0]  in_datak_i,
  input  logic [3:0]  in_ts_i,
  input  logic        in_scramble_en_i,
  input  logic        skp_req_i,
  output logic [31:0] data_o,
  output logic [3:0]  datak_o,
  output logic [3:0]  training_sequence_o,
  output logic [1:0]  data_len_o,
  output logic        scramble_enable_o,
  output logic        out_valid_o,
  output logic        skp_sent_o
);

  skp_state_e state_q, state_d;
  logic [1:0] ts_cnt_q;
  logic       skp_pending;
  logic       skp_emit;
  logic       accept;

  gen1_skp_timer #(
    .SKP_INTERVAL_WORDS(SKP_INTERVAL_WORDS)
  ) u_timer (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .skp_req_i    (skp_req_i),
    .word_sent_i  (!rst_i && !skp_emit),
    .skp_sent_i   (skp_emit),
    .skp_pending_o(skp_pending)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_PASS;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    skp_emit = 1'b0;
    if (!rst_i) begin
      unique case (state_q)
        ST_PASS: begin
          if (skp_pending) begin
            if (ts_cnt_q == 2'd0) begin
              skp_emit = 1'b1;
            end else begin
              state_d = ST_SKP_WAIT;
            end
          end
        end
        ST_SKP_WAIT: begin
          if (ts_cnt_q == 2'd0) begin
            skp_emit = 1'b1;
            state_d  = ST_PASS;
          end
        end
        default: state_d = ST_PASS;
      endcase
    end
  end

  assign in_ready_o = !skp_emit;
  assign accept     = in_valid_i && !skp_emit && !rst_i;
  assign data_len_o = DATA_LEN_4B;

  // Position within a 4-word TS ordered set; SKP only at position 0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ts_cnt_q <= 2'd0;
    end else if (accept && |in_ts_i) begin
      ts_cnt_q <= ts_cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_o         <= 1'b0;
      data_o              <= '0;
      datak_o             <= '0;
      training_sequence_o <= '0;
      scramble_enable_o   <= 1'b0;
      skp_sent_o          <= 1'b0;
    end else begin
      out_valid_o <= 1'b1;
      skp_sent_o  <= skp_emit;
      if (skp_emit) begin
        data_o              <= SKP_WORD;
        datak_o             <= 4'hF;
        training_sequence_o <= 4'h0;
      end else if (accept) begin
        data_o              <= in_data_i;
        datak_o             <= in_datak_i;
        training_sequence_o <= in_ts_i;
        scramble_enable_o   <= in_scramble_en_i;
      end else begin
        data_o              <= '0;
        datak_o             <= '0;
        training_sequence_o <= '0;
      end
    end
  end

endmodule
